// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared operation and FSM state encodings for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic {OP_MULT, OP_DIV} op_e;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

endpackage

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencing FSM and step counter for multdiv_unit.
// A strobe aborts the current operation and parks in IDLE with a pending go, so RUN starts one cycle after capture.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   start,
    output state_e state,
    output logic   busy,
    output logic   rdy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;
    logic          go;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            go    <= 1'b0;
            busy  <= 1'b0;
            rdy   <= 1'b0;
        end else if (start) begin
            state <= IDLE;
            count <= '0;
            go    <= 1'b1;
            busy  <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            go <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state <= RUN;
                    count <= '0;
                    busy  <= 1'b1;
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    rdy   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative WIDTH-step shift-add multiplier / restoring divider on operand magnitudes.
// Optional MULTDIV_REMAINDER_EN adds the data_remainder output.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int W = WIDTH;

    state_e         state;
    op_e            op;
    logic           start, is_div, sgn, neg_a, neg_b, div_zero, div_ovf;
    logic           in_neg_a, in_neg_b;
    logic [W-1:0]   in_mag_a, in_mag_b;
    logic [W-1:0]   hi, lo, mag_a, mag_b;
    logic [W:0]     x, y;
    logic [W+1:0]   sum;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s, rem_s;
    logic           mult_exc;

    assign start  = ctrl_MULT | ctrl_DIV;
    assign is_div = (op == OP_DIV);

    multdiv_ctrl #(.WIDTH(W)) u_ctrl (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .state   (state),
        .busy    (busy),
        .rdy     (data_resultRDY)
    );

    always_comb begin
        in_neg_a = ctrl_signed & data_operandA[W-1];
        in_neg_b = ctrl_signed & data_operandB[W-1];
        in_mag_a = in_neg_a ? -data_operandA : data_operandA;
        in_mag_b = in_neg_b ? -data_operandB : data_operandB;
        // Shared adder: mult adds the multiplicand to the high half, div subtracts the divisor from the shifted remainder.
        x        = is_div ? {hi, lo[W-1]} : {1'b0, hi};
        y        = is_div ? ~{1'b0, mag_b} : {1'b0, mag_a};
        sum      = {1'b0, x} + {1'b0, y} + (W+2)'(is_div);
        prod_s   = (sgn && (neg_a ^ neg_b)) ? -{hi, lo} : {hi, lo};
        quot_s   = (sgn && (neg_a ^ neg_b)) ? -lo : lo;
        rem_s    = (sgn && neg_a) ? -hi : hi;
        mult_exc = sgn ? (prod_s[2*W-1:W] != {W{prod_s[W-1]}}) : (|prod_s[2*W-1:W]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op             <= OP_MULT;
            sgn            <= 1'b0;
            neg_a          <= 1'b0;
            neg_b          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            mag_a          <= '0;
            mag_b          <= '0;
            hi             <= '0;
            lo             <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else if (start) begin
            op       <= ctrl_MULT ? OP_MULT : OP_DIV;
            sgn      <= ctrl_signed;
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            div_zero <= (data_operandB == '0);
            div_ovf  <= ctrl_signed && (data_operandA == {1'b1, {(W-1){1'b0}}}) && (&data_operandB);
            mag_a    <= in_mag_a;
            mag_b    <= in_mag_b;
            hi       <= '0;
            lo       <= ctrl_MULT ? in_mag_b : in_mag_a;
        end else if (state == RUN) begin
            {hi, lo} <= is_div
                ? (sum[W+1] ? {sum[W-1:0], lo[W-2:0], 1'b1} : {x[W-1:0], lo[W-2:0], 1'b0})
                : (lo[0] ? {sum[W:0], lo[W-1:1]} : {1'b0, hi, lo[W-1:1]});
        end else if (state == FIX) begin
            data_result    <= is_div ? (div_zero ? '0 : quot_s) : prod_s[W-1:0];
            data_exception <= is_div ? (div_zero | div_ovf) : mult_exc;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= (is_div && !div_zero) ? rem_s : '0;
`endif
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed and randomized checks of multdiv_unit (WIDTH=32) against an arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0, ctrl_signed = 1'b0;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
`ifdef MULTDIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif
    int n_tests = 0, n_fail = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_signed    (ctrl_signed),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef MULTDIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit mul, input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output logic [31:0] rm);
        longint      ps;
        logic [63:0] pu;
        int          sa, sb;
        rm = '0;
        if (mul) begin
            if (sg) begin
                ps = longint'($signed(a)) * longint'($signed(b));
                r  = ps[31:0];
                e  = (ps > 64'sd2147483647) || (ps < -64'sd2147483648);
            end else begin
                pu = 64'(a) * 64'(b);
                r  = pu[31:0];
                e  = (pu[63:32] != 0);
            end
        end else if (b == 0) begin
            r = '0;
            e = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = a;
            e = 1'b1;
        end else if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            r  = sa / sb;
            rm = sa % sb;
            e  = 1'b0;
        end else begin
            r  = a / b;
            rm = a % b;
            e  = 1'b0;
        end
    endfunction

    task automatic start_op(input bit mul, input bit sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_signed   = sg;
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ctrl_signed   = 1'($urandom);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] er, input logic ee, input logic [31:0] erm);
        int          n = 0, nb = 0;
        logic [31:0] held;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (busy) nb++;
        end while (!data_resultRDY && n < 100);
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        check({tag, "_result"}, 64'(data_result), 64'(er));
        check({tag, "_exception"}, 64'(data_exception), 64'(ee));
`ifdef MULTDIV_REMAINDER_EN
        check({tag, "_remainder"}, 64'(data_remainder), 64'(erm));
`else
        if (erm != erm) $display("unreachable");
`endif
        held = data_result;
        @(posedge clock);
        #1;
        check({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'd0);
        check({tag, "_hold"}, 64'(data_result), 64'(held));
    endtask

    task automatic run_op(input string tag, input bit mul, input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r, rm;
        logic        e;
        model(mul, sg, a, b, r, e, rm);
        start_op(mul, sg, a, b);
        finish_op(tag, r, e, rm);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF};
        case ($urandom_range(0, 4))
            0:       return sp[$urandom_range(0, 3)];
            1:       return 32'($urandom_range(0, 15));
            2:       return -32'($urandom_range(1, 15));
            3:       return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int spurious;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exception", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        check_directed: begin
            run_op("umul_7x6", 1, 0, 32'd7, 32'd6);
            check("umul_7x6_value", 64'(data_result), 64'd42);
            run_op("smul_m3x5", 1, 1, 32'hFFFF_FFFD, 32'd5);
            check("smul_m3x5_value", 64'(data_result), 64'hFFFF_FFF1);
            run_op("umul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000);
            check("umul_ovf_exc", 64'(data_exception), 64'd1);
            run_op("sdiv_m7d2", 0, 1, 32'hFFFF_FFF9, 32'd2);
            check("sdiv_m7d2_value", 64'(data_result), 64'hFFFF_FFFD);
            run_op("sdiv_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
            run_op("div_by_zero", 0, 0, 32'd5, 32'd0);
            check("div_by_zero_exc", 64'(data_exception), 64'd1);
        end

        // abort: mult 3x4 then div 100/7 ten cycles after its capture edge
        spurious = 0;
        start_op(1, 0, 32'd3, 32'd4);
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) spurious++;
        end
        start_op(0, 0, 32'd100, 32'd7);
        finish_op("abort_div", 32'd14, 1'b0, 32'd2);
        check("abort_no_mult_pulse", 64'(spurious), 64'd0);

        // reset mid-operation
        run_op("pre_reset", 1, 0, 32'd7, 32'd6);
        start_op(1, 0, 32'd9, 32'd9);
        repeat (15) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_result", 64'(data_result), 64'd0);
        check("async_rst_exc", 64'(data_exception), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        spurious = 0;
        repeat (60) begin
            @(posedge clock);
            #1;
            if (data_resultRDY || busy) spurious++;
        end
        check("post_reset_quiet", 64'(spurious), 64'd0);

        for (int i = 0; i < 150; i++) begin
            bit mul = 1'($urandom);
            bit sg  = 1'($urandom);
            run_op($sformatf("rand%0d_%s%s", i, sg ? "s" : "u", mul ? "mul" : "div"), mul, sg, pick(), pick());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (even, >= 4).
REQ-002 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: data_operandA  input  WIDTH  multiplicand / dividend.
REQ-005 SHALL have port: data_operandB  input  WIDTH  multiplier / divisor.
REQ-006 SHALL have port: ctrl_MULT  input  1  single-cycle start-multiply strobe.
REQ-007 SHALL have port: ctrl_DIV  input  1  single-cycle start-divide strobe.
REQ-008 SHALL have port: ctrl_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the start strobe.
REQ-009 SHALL have port: data_result  output  WIDTH  low WIDTH bits of product, or quotient.
REQ-010 SHALL have port: data_exception  output  1  error flag, valid while data_resultRDY=1.
REQ-011 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: busy  output  1  operation in progress.
REQ-013 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-014 SHALL capture operands, op and ctrl_signed at the edge E0 where ctrl_MULT or ctrl_DIV is 1; inputs are ignored thereafter.
REQ-015 SHALL give ctrl_MULT priority when both strobes are 1 in the same cycle.
REQ-016 SHALL implement FSM IDLE -> RUN -> FIX -> DONE -> IDLE; RUN lasts exactly WIDTH cycles, with one shift-add (mult) or restoring-subtract (div) step per cycle on operand magnitudes.
REQ-017 SHALL apply sign correction in FIX; data_resultRDY SHALL be 1 only in DONE, i.e. rising at edge E0+WIDTH+2, high for one cycle.
REQ-018 SHALL hold data_result and data_exception stable from DONE until the next start strobe.
REQ-019 SHALL drive busy=1 in RUN and FIX, 0 in IDLE and DONE.
REQ-020 SHALL treat a start strobe in any state as abort-and-restart: prior operation discarded, no data_resultRDY for it, new E0 defined.
REQ-021 SHALL set mult exception when the full 2*WIDTH product is not representable in WIDTH bits (unsigned: upper half non-zero; signed: upper half not equal to sign-extension of bit WIDTH-1).
REQ-022 SHALL on divisor=0 return data_result=0 and data_exception=1 with normal latency.
REQ-023 SHALL truncate signed quotients toward zero; signed MIN/-1 SHALL return MIN with data_exception=1.

Reset
REQ-024 SHALL, on reset_n=0, force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0, immediately and independent of clock.
REQ-025 SHALL abandon an operation in progress on reset; no data_resultRDY until a new strobe after reset_n deasserts.

Configuration
REQ-026 SHALL, with MULTDIV_REMAINDER_EN defined, add output port data_remainder (WIDTH): division remainder, sign following dividend, 0 on divide-by-zero, 0 after a multiply, reset 0, same timing as data_result.
REQ-027 SHALL, without MULTDIV_REMAINDER_EN, omit data_remainder and its register; all other behaviour identical.

Structure
REQ-028 SHALL place op enum (OP_MULT, OP_DIV) and FSM state enum (IDLE, RUN, FIX, DONE) in shared package multdiv_pkg.
REQ-029 SHALL place the FSM and the $clog2(WIDTH+1)-bit step counter in sub-module multdiv_ctrl; datapath (2*WIDTH-bit shift register, adder/subtractor) in multdiv_unit.

Verification (WIDTH=32)
REQ-030 SHALL cover: unsigned mult 7 x 6 -> data_result=42, exception 0, data_resultRDY high exactly in cycle E0+34, busy 1 for 33 cycles.
REQ-031 SHALL cover: signed mult 0xFFFFFFFD x 5 -> 0xFFFFFFF1, exception 0; unsigned 0x00010000 x 0x00010000 -> 0, exception 1.
REQ-032 SHALL cover: signed div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD (remainder 0xFFFFFFFF with MULTDIV_REMAINDER_EN); signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
REQ-033 SHALL cover: div 5 / 0 -> result 0, exception 1, same latency as REQ-030.
REQ-034 SHALL cover: mult 3 x 4 started, div 100 / 7 strobed 10 cycles later -> single data_resultRDY at new E0+34 with result 14; no pulse for the mult.
REQ-035 SHALL cover: reset_n low at E0+15 of a mult -> all outputs 0 asynchronously, no data_resultRDY afterwards without a new strobe.
